tone_detector: RTL and testbench
================================

// Module: tone_detector
// PURPOSE
//  Receive end of the tone path: takes the square wave arriving on a PMOD pin (as produced by the
//  switch-decoder + clock-divider tone generator) and recovers which of the 8 notes is playing.
//  Measures the half-period in CLK cycles and matches it against the shared note table.
//  Drives a one-hot note estimate (switch-style) plus lock status, e.g. to LEDs or a 7-seg driver.
// PARAMETERS
//  TOL          256        max |measured - expected| half-period error, CLK cycles, for a match
//  N_CONFIRM    4          consecutive matching half-periods needed to lock (>=1)
//  TIMEOUT_CYC  1_000_000  CLK cycles with no edge before declaring silence (10 ms @ 100 MHz)
// PORTS
//  CLK        in   1   system clock, 100 MHz
//  RST        in   1   asynchronous, active-high reset
//  SIN        in   1   asynchronous square-wave input from PMOD
//  NOTE_OH    out  8   one-hot detected note, bit i = table entry i; 0 when not locked
//  NOTE_VLD   out  1   high while LOCKED
//  NOTE_NEW   out  1   one-cycle pulse on entry to LOCKED or a locked-note change
//  HALF_PER   out  17  last completed half-period measurement, saturating at 17'h1FFFF
// BEHAVIOUR
//  Reset (async, RST=1): all outputs 0, state IDLE, counters 0, synchronizer flops 0.
//  Input: 2-flop synchronizer on SIN, then 3rd flop for edge detect; edge = either transition.
//   Edge visible to FSM 3 CLK after pin transition; fixed latency, cancels between edges.
//  Counter: 20-bit CNT, +1 per cycle, cleared to 1 on each edge, saturates at TIMEOUT_CYC.
//   Half-period HP = CNT value at the edge cycle (cycles since previous edge), clipped to 17 bits.
//  Match: expected_i = NOTE_MAXCOUNT[i]+1; HP matches i iff |HP - expected_i| <= TOL (unsigned
//   compare after ordering, no wrap). Lowest index wins if several match. HP > 17'h1FFFF never matches.
//  FSM states:
//   IDLE    : no edge history. edge -> MEASURE (CNT restart).
//   MEASURE : edge: HP matches i -> CONFIRM(cand=i, hits=1; N_CONFIRM=1 -> LOCKED); else stay.
//   CONFIRM : edge: match cand -> hits+1, reaching N_CONFIRM -> LOCKED;
//             match other j -> cand=j, hits=1; no match -> MEASURE.
//   LOCKED  : edge: match cand -> stay; match j!=cand -> CONFIRM(cand=j, hits=1);
//             no match -> MEASURE. NOTE_VLD/NOTE_OH drop the cycle after leaving LOCKED.
//   Any state except IDLE: CNT reaches TIMEOUT_CYC -> IDLE (silence).
//  Outputs registered: NOTE_OH/NOTE_VLD update the cycle after the deciding edge; NOTE_NEW
//   pulses in that same cycle; HALF_PER updates on every edge (in all states except IDLE).
//  Simultaneous edge and timeout in one cycle: edge wins, timeout ignored.
//  First edge after IDLE yields no HP (no prior edge); first measurement is the second edge.
//  DC input (stuck 0 or 1): no edges -> IDLE after TIMEOUT_CYC; outputs 0.
//  RST mid-lock: outputs clear immediately (async); relock needs N_CONFIRM+1 edges after release.
// STRUCTURE
//  tone_pkg (shared with switch decoder): NUM_NOTES=8, MC_W=17, NOTE_MAXCOUNT[0:7] =
//   {95556,85131,75843,71586,63776,56818,50619,47778} (C5..C6 @ 100 MHz), state enum
//   {IDLE,MEASURE,CONFIRM,LOCKED}. Switch decoder must source its values from this package.
//  Sub-module edge_sync: 2-flop sync + edge-detect flop, async RST, outputs sync level + edge pulse.
//  Top: counter, match comparators (8 parallel), FSM, output registers.
// TESTING
//  1. Reset: RST=1 with SIN toggling -> all outputs 0; release, no SIN edges -> stay 0.
//  2. Lock A5: SIN half-period 56819 cycles, 6 edges -> NOTE_OH=8'b0010_0000, NOTE_VLD=1,
//     one NOTE_NEW pulse after 5th edge (N_CONFIRM=4), HALF_PER=56819.
//  3. Tolerance: half-periods 95557+256 -> locks bit0; 95557+257 -> never locks, HALF_PER=95814.
//  4. Change C6->E5 while locked: NOTE_VLD low after first 75844 HP, relock bit2 4 edges later,
//     NOTE_NEW pulse; stop SIN -> IDLE and outputs 0 exactly TIMEOUT_CYC after last edge.
//  5. Edge landing in the exact cycle CNT hits TIMEOUT_CYC (TIMEOUT_CYC overridden to 100000)
//     -> stays tracking, no drop to IDLE; RST pulse mid-lock -> outputs 0 same cycle.
//  6. Random SIN jitter within +-200 cycles on every table note -> correct one-hot, no glitches.

Source files
------------

// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared note table, widths, detector states and match helper
// Used by the tone generator's switch decoder and by tone_detector, so both
// ends of the tone path agree on the divider values for each note.
package tone_pkg;

    localparam int NUM_NOTES = 8;
    localparam int MC_W      = 17;
    localparam int IDX_W     = $clog2(NUM_NOTES);
    localparam int CNT_W     = 20;

    typedef logic [MC_W-1:0] maxcount_t;
    typedef logic [0:NUM_NOTES-1][MC_W-1:0] note_table_t;

    // Divider terminal counts for C5..C6 at 100 MHz; half-period is value+1.
    localparam note_table_t NOTE_MAXCOUNT = '{
        17'd95556, 17'd85131, 17'd75843, 17'd71586,
        17'd63776, 17'd56818, 17'd50619, 17'd47778
    };

    typedef enum logic [1:0] {IDLE, MEASURE, CONFIRM, LOCKED} tone_state_t;

    // True when a measured half-period lies within tol of maxcount+1.
    // Measurements above the 17-bit range never match.
    function automatic logic hp_matches(input logic [CNT_W-1:0] hp,
                                        input maxcount_t        maxcount,
                                        input logic [CNT_W-1:0] tol);
        logic [CNT_W-1:0] expected;
        logic [CNT_W-1:0] diff;
        expected = {{(CNT_W-MC_W){1'b0}}, maxcount} + CNT_W'(1);
        diff     = (hp >= expected) ? (hp - expected) : (expected - hp);
        return (hp <= CNT_W'(20'h1FFFF)) && (diff <= tol);
    endfunction

endpackage

// File: rtl/tone_detector_edge_sync.sv
// rtl/tone_detector_edge_sync.sv - two-flop synchronizer plus edge-detect flop
// Ports: clk, rst (async active-high), din (asynchronous pin),
//        toggle (one-cycle pulse on either transition of the synchronized level).
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic toggle
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign toggle = s2 ^ s3;

endmodule

// File: rtl/tone_detector.sv
// rtl/tone_detector.sv - recovers the playing note from the tone square wave
// Ports: CLK, RST (async active-high), SIN (asynchronous square wave),
//        NOTE_OH (one-hot locked note), NOTE_VLD (locked), NOTE_NEW (lock/change pulse),
//        HALF_PER (last half-period in CLK cycles, saturating).
// NOTE_TABLE defaults to the shared table; it is a parameter so a scaled
// table can be used when the absolute audio periods are impractical.
module tone_detector
    import tone_pkg::*;
#(
    parameter int          TOL         = 256,
    parameter int          N_CONFIRM   = 4,
    parameter int          TIMEOUT_CYC = 1_000_000,
    parameter note_table_t NOTE_TABLE  = NOTE_MAXCOUNT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SIN,
    output logic [NUM_NOTES-1:0] NOTE_OH,
    output logic                 NOTE_VLD,
    output logic                 NOTE_NEW,
    output logic [MC_W-1:0]      HALF_PER
);

    localparam int               HIT_W     = $clog2(N_CONFIRM + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TOL_V     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] HP_MAX    = CNT_W'(20'h1FFFF);
    localparam logic [HIT_W-1:0] HITS_LOCK = HIT_W'(N_CONFIRM);

    logic toggle;

    edge_sync u_sync (
        .clk    (CLK),
        .rst    (RST),
        .din    (SIN),
        .toggle (toggle)
    );

    logic [CNT_W-1:0] cnt;
    tone_state_t      state, state_nx;
    logic [IDX_W-1:0] cand, cand_nx;
    logic [HIT_W-1:0] hits, hits_nx;
    logic             match_hit;
    logic [IDX_W-1:0] match_idx;
    logic [MC_W-1:0]  hp_clip;

    // cnt holds the cycles since the previous edge when an edge arrives.
    assign hp_clip = (cnt > HP_MAX) ? MC_W'(17'h1FFFF) : cnt[MC_W-1:0];

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NUM_NOTES - 1; i >= 0; i--) begin
            if (hp_matches(cnt, NOTE_TABLE[i], TOL_V)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    // hits counts consecutive matches of cand and saturates at N_CONFIRM,
    // so LOCKED is simply "hits reached N_CONFIRM".
    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        hits_nx  = hits;
        if (toggle) begin
            if (state == IDLE) begin
                state_nx = MEASURE;
                hits_nx  = '0;
            end else if (!match_hit) begin
                state_nx = MEASURE;
                hits_nx  = '0;
            end else begin
                if (state != MEASURE && match_idx == cand) begin
                    if (hits != HITS_LOCK) begin
                        hits_nx = hits + HIT_W'(1);
                    end
                end else begin
                    cand_nx = match_idx;
                    hits_nx = HIT_W'(1);
                end
                state_nx = (hits_nx == HITS_LOCK) ? LOCKED : CONFIRM;
            end
        end else if (state != IDLE && cnt >= TIMEOUT_V) begin
            state_nx = IDLE;
            hits_nx  = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cand  <= '0;
            hits  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cand  <= cand_nx;
            hits  <= hits_nx;
            if (toggle) begin
                cnt <= CNT_W'(1);
            end else if (state_nx == IDLE) begin
                cnt <= '0;
            end else if (cnt < TIMEOUT_V) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            NOTE_OH  <= '0;
            NOTE_VLD <= 1'b0;
            NOTE_NEW <= 1'b0;
            HALF_PER <= '0;
        end else begin
            NOTE_VLD <= (state_nx == LOCKED);
            NOTE_OH  <= (state_nx == LOCKED) ? (NUM_NOTES'(1) << cand_nx) : '0;
            NOTE_NEW <= (state_nx == LOCKED) && (state != LOCKED || cand_nx != cand);
            if (toggle && state != IDLE) begin
                HALF_PER <= hp_clip;
            end else if (state_nx == IDLE) begin
                HALF_PER <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tone_detector.sv
// tb/tb_tone_detector.sv - self-checking bench for tone_detector with a scaled note table
module tb_tone_detector;
    import tone_pkg::*;

    localparam int TOL_T = 4;
    localparam int NC    = 4;
    localparam int TO    = 1000;
    localparam note_table_t TB_TABLE = '{
        17'd478, 17'd426, 17'd379, 17'd358, 17'd319, 17'd284, 17'd253, 17'd239
    };

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SIN = 1'b0;
    logic [7:0]  NOTE_OH;
    logic        NOTE_VLD;
    logic        NOTE_NEW;
    logic [16:0] HALF_PER;

    tone_detector #(
        .TOL(TOL_T), .N_CONFIRM(NC), .TIMEOUT_CYC(TO), .NOTE_TABLE(TB_TABLE)
    ) dut (
        .CLK(CLK), .RST(RST), .SIN(SIN),
        .NOTE_OH(NOTE_OH), .NOTE_VLD(NOTE_VLD), .NOTE_NEW(NOTE_NEW), .HALF_PER(HALF_PER)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int new_count = 0;

    // Expected half-period of each note in cycles (table value + 1).
    int note_period[8] = '{479, 427, 380, 359, 320, 285, 254, 240};

    // Reference model: pin history, time of last edge, and the run of
    // consecutive half-periods that classified as the same note.
    int         cyc = 0;
    bit         pin_hist[4];
    bit         active = 0;
    int         last_edge = 0;
    int         run_note = 0;
    int         run_len = 0;
    bit         prev_locked = 0;
    int         prev_note = 0;
    logic [7:0] m_oh = 0;
    bit         m_vld = 0;
    bit         m_new = 0;
    int         m_hp = 0;

    function automatic int classify(input int hp);
        for (int i = 0; i < 8; i++) begin
            int d;
            d = hp - note_period[i];
            if (d < 0) d = -d;
            if (hp <= 131071 && d <= TOL_T) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit locked;
        if (RST) begin
            for (int i = 0; i < 4; i++) pin_hist[i] = 0;
            active = 0; run_len = 0; prev_locked = 0;
            m_oh = 0; m_vld = 0; m_new = 0; m_hp = 0;
            return;
        end
        cyc++;
        for (int i = 3; i > 0; i--) pin_hist[i] = pin_hist[i-1];
        pin_hist[0] = SIN;
        // The pin value seen at this edge reaches the decision logic two edges later.
        if (pin_hist[2] ^ pin_hist[3]) begin
            if (!active) begin
                active = 1;
                last_edge = cyc;
            end else begin
                int hp, k;
                hp = cyc - last_edge;
                last_edge = cyc;
                m_hp = (hp > 131071) ? 131071 : hp;
                k = classify(hp);
                if (k < 0) run_len = 0;
                else if (run_len > 0 && k == run_note) run_len++;
                else begin run_note = k; run_len = 1; end
            end
        end else if (active && (cyc - last_edge) >= TO) begin
            active = 0; run_len = 0; m_hp = 0;
        end
        locked = (run_len >= NC);
        m_vld = locked;
        m_oh  = locked ? 8'(1 << run_note) : 8'd0;
        m_new = locked && (!prev_locked || run_note != prev_note);
        prev_locked = locked;
        prev_note = run_note;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK or posedge RST);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST) begin
                check("cyc_note_oh", NOTE_OH, m_oh);
                check("cyc_note_vld", NOTE_VLD, m_vld);
                check("cyc_note_new", NOTE_NEW, m_new);
                check("cyc_half_per", HALF_PER, m_hp);
                if (NOTE_NEW) new_count++;
            end
        end
    end

    task automatic toggle_after(input int n);
        repeat (n) @(negedge CLK);
        SIN = ~SIN;
    endtask

    task automatic settle();
        repeat (4) @(negedge CLK);
    endtask

    task automatic go_idle();
        repeat (TO + 20) @(negedge CLK);
        check("idle_vld", NOTE_VLD, 0);
        check("idle_half_per", HALF_PER, 0);
    endtask

    initial begin
        int nc0;
        int idx;
        int hp;

        // 1. Reset holds everything at zero even with SIN moving.
        for (int i = 0; i < 6; i++) begin
            repeat (3) @(negedge CLK);
            SIN = ~SIN;
            #1;
            check("rst_oh", NOTE_OH, 0);
            check("rst_vld", NOTE_VLD, 0);
            check("rst_new", NOTE_NEW, 0);
            check("rst_hp", HALF_PER, 0);
        end
        SIN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        repeat (50) @(negedge CLK);
        check("quiet_vld", NOTE_VLD, 0);
        check("quiet_oh", NOTE_OH, 0);

        // 2. Lock A5 (entry 5) with six edges.
        nc0 = new_count;
        repeat (6) toggle_after(285);
        settle();
        check("a5_oh", NOTE_OH, 8'b0010_0000);
        check("a5_vld", NOTE_VLD, 1);
        check("a5_hp", HALF_PER, 285);
        check("a5_new_pulses", new_count - nc0, 1);
        go_idle();

        // 3. Tolerance edges around entry 0.
        repeat (6) toggle_after(479 + TOL_T);
        settle();
        check("tol_hi_oh", NOTE_OH, 8'b0000_0001);
        go_idle();
        repeat (6) toggle_after(479 - TOL_T);
        settle();
        check("tol_lo_oh", NOTE_OH, 8'b0000_0001);
        go_idle();
        repeat (6) toggle_after(479 + TOL_T + 1);
        settle();
        check("tol_out_vld", NOTE_VLD, 0);
        check("tol_out_oh", NOTE_OH, 0);
        check("tol_out_hp", HALF_PER, 484);
        go_idle();

        // 4. C6 -> E5 while locked, then silence.
        repeat (6) toggle_after(240);
        settle();
        check("c6_oh", NOTE_OH, 8'b1000_0000);
        nc0 = new_count;
        toggle_after(380 - 4);
        settle();
        check("chg_drop_vld", NOTE_VLD, 0);
        toggle_after(380 - 4);
        toggle_after(380);
        toggle_after(380);
        settle();
        check("e5_oh", NOTE_OH, 8'b0000_0100);
        check("e5_new_pulses", new_count - nc0, 1);
        repeat (TO - 14) @(negedge CLK);
        check("pre_timeout_vld", NOTE_VLD, 1);
        repeat (20) @(negedge CLK);
        check("post_timeout_vld", NOTE_VLD, 0);
        check("post_timeout_oh", NOTE_OH, 0);

        // 5. Edge exactly at the timeout count keeps tracking; async reset mid-lock.
        repeat (6) toggle_after(285);
        settle();
        check("t5_lock_vld", NOTE_VLD, 1);
        toggle_after(TO - 4);
        settle();
        check("at_to_hp", HALF_PER, TO);
        check("at_to_vld", NOTE_VLD, 0);
        toggle_after(285 - 4);
        settle();
        check("after_to_hp", HALF_PER, 285);
        toggle_after(285 - 4);
        toggle_after(285);
        toggle_after(285);
        settle();
        check("relock_vld", NOTE_VLD, 1);
        check("relock_oh", NOTE_OH, 8'b0010_0000);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("async_rst_vld", NOTE_VLD, 0);
        check("async_rst_oh", NOTE_OH, 0);
        check("async_rst_hp", HALF_PER, 0);
        @(negedge CLK);
        SIN = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (4) toggle_after(285);
        settle();
        check("post_rst_4_vld", NOTE_VLD, 0);
        toggle_after(285 - 4);
        settle();
        check("post_rst_5_vld", NOTE_VLD, 1);
        go_idle();

        // 6. Random jitter on randomly chosen notes, streamed back to back.
        for (int n = 0; n < 10; n++) begin
            idx = $urandom_range(0, 7);
            for (int e = 0; e < 6; e++) begin
                hp = note_period[idx] + int'($urandom_range(0, 6)) - 3;
                toggle_after((n > 0 && e == 0) ? hp - 4 : hp);
            end
            settle();
            check("rand_oh", NOTE_OH, 32'(1 << idx));
            check("rand_vld", NOTE_VLD, 1);
        end
        go_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
